// File: rtl/mem_access_unit.sv
// Load/store controller in front of a synchronous-read data memory.
// It runs one access at a time and is the only side driving the shared data bus during a store.
module mem_access_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic                    oe_q, oe_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? WR : RD_ADDR;
        end
      end
      WR:      state_d = IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d = mem_data;
        state_d = RSP;
      end
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Memory pins are decoded from the next state so they are glitch-free flops.
    cs_d    = (state_d == WR) || (state_d == RD_ADDR) || (state_d == RD_DATA);
    we_d    = (state_d == WR);
    oe_d    = (state_d == RD_ADDR) || (state_d == RD_DATA);
    maddr_d = cs_d ? addr_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      maddr_q <= maddr_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;
  assign mem_addr  = maddr_q;

  // Only WR drives the bus; the memory drives only with oe set and we clear.
  assign mem_data = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous-read memory on the shared bus.
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       mem_cs;
  logic       mem_we;
  logic       mem_oe;
  logic [7:0] mem_addr;
  wire  [7:0] mem_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic [7:0] rd_q;
  logic       mem_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  // Memory stand-in: writes on the edge, registered read data driven while cs && oe && !we.
  assign mem_rd   = mem_cs && mem_oe && !mem_we;
  assign mem_data = mem_rd ? rd_q : 8'bz;

  always @(posedge clk) begin
    if (mem_cs && mem_we) mem[mem_addr] <= mem_data;
    if (mem_rd) rd_q <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus ownership watch on every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_rd)
        chk("bus_rd", {24'h0, mem_data}, {24'h0, rd_q});
      else if (!mem_cs)
        chk("bus_idle", {31'h0, ($isunknown(mem_data) || mem_data == 8'h00)}, 32'h1);
    end
  end

  task automatic do_store(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    chk("st_rdy", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_ctl",  {29'h0, mem_cs, mem_we, mem_oe}, 32'h6);
    chk("wr_addr", {24'h0, mem_addr}, {24'h0, a});
    chk("wr_data", {24'h0, mem_data}, {24'h0, d});
    chk("wr_rdy",  {31'h0, req_ready}, 32'h0);
    model[a] = d;
    @(posedge clk);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] exp, input int hold);
    @(negedge clk);
    chk("ld_rdy", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ra_ctl",  {29'h0, mem_cs, mem_we, mem_oe}, 32'h5);
    chk("ra_addr", {24'h0, mem_addr}, {24'h0, a});
    chk("ra_vld",  {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rd_ctl",  {29'h0, mem_cs, mem_we, mem_oe}, 32'h5);
    chk("rd_vld",  {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_vld",  {31'h0, rsp_valid}, 32'h1);
    chk("rsp_data", {24'h0, rsp_rdata}, {24'h0, exp});
    chk("rsp_ctl",  {29'h0, mem_cs, mem_we, mem_oe}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      chk("hold_vld",  {31'h0, rsp_valid}, 32'h1);
      chk("hold_data", {24'h0, rsp_rdata}, {24'h0, exp});
      chk("hold_cs",   {31'h0, mem_cs}, 32'h0);
      chk("hold_rdy",  {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done_vld",  {31'h0, rsp_valid}, 32'h0);
    chk("done_rdy",  {31'h0, req_ready}, 32'h1);
    chk("done_keep", {24'h0, rsp_rdata}, {24'h0, exp});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      model[i] = 8'h00;
    end
    rd_q = 8'h00;
  end

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ctl", {29'h0, mem_cs, mem_we, mem_oe}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy",   {31'h0, req_ready}, 32'h1);
    chk("rst_vld",   {31'h0, rsp_valid}, 32'h0);
    chk("rst_ctl",   {29'h0, mem_cs, mem_we, mem_oe}, 32'h0);
    chk("rst_addr",  {24'h0, mem_addr}, 32'h0);
    chk("rst_rdata", {24'h0, rsp_rdata}, 32'h0);

    do_store(8'h10, 8'hA5);
    do_load(8'h10, 8'hA5, 0);

    do_store(8'h00, 8'h11);
    do_store(8'hFF, 8'h22);
    do_load(8'hFF, 8'h22, 0);
    do_load(8'h00, 8'h11, 0);

    do_load(8'h10, 8'hA5, 5);
    do_load(8'h10, 8'hA5, 0);

    // Reset lands while the store to 0x20 is in its WR cycle.
    do_store(8'h20, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h5A;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rstwr_cs",  {31'h0, mem_cs}, 32'h0);
    chk("rstwr_we",  {31'h0, mem_we}, 32'h0);
    chk("rstwr_rdy", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(8'h20, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) do_store(a, d);
      else do_load(a, model[a], 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
